// File: rtl/simd_shift_pipe.sv
// Pipelined SIMD shift/rotate unit: 1x64, 2x32, 4x16 or 8x8 lanes with a valid/ready handshake on both sides.
// Define SIMD_SHIFT_SAT_EN to enable type 110, the saturating signed left shift, and the out_sat flag.
module simd_shift_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [5:0]            in_amt,
  input  logic [2:0]            in_type,
  input  logic [1:0]            in_lane,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_sat
);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000, OP_SLL = 3'b001, OP_SRL = 3'b010, OP_SRA = 3'b011,
    OP_ROL  = 3'b100, OP_ROR = 3'b101, OP_SSLL = 3'b110, OP_RSVD = 3'b111
  } op_e;

  // Shift one lane held zero-extended in 64 bits; bit 64 of the result is the saturation flag.
  function automatic logic [64:0] lane_op(input logic [63:0] x, input int w,
                                          input logic [5:0] amt, input op_e op);
    logic [63:0] mask, sx, r;
    logic [5:0]  a;
    logic        sat;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = amt & 6'(w - 1);
    sx   = x[w-1] ? (x | ~mask) : x;
    r    = '0;
    sat  = 1'b0;
    case (op)
      OP_SLL: r = x << a;
      OP_SRL: r = x >> a;
      OP_SRA: r = $signed(sx) >>> a;
      OP_ROL: r = (x << a) | (x >> (w - int'(a)));
      OP_ROR: r = (x >> a) | (x << (w - int'(a)));
`ifdef SIMD_SHIFT_SAT_EN
      OP_SSLL: begin
        // The top a+1 bits must all equal the sign, otherwise the shift overflows.
        logic [63:0] hi;
        hi = $signed(sx) >>> (w - 1 - int'(a));
        if (hi != '0 && hi != '1) begin
          sat = 1'b1;
          r   = x[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
        end else begin
          r = x << a;
        end
      end
`endif
      default: r = '0;
    endcase
    return {sat, r & mask};
  endfunction

  function automatic logic [5:0] amt_eff(input logic [5:0] amt, input logic [1:0] lane);
    case (lane)
      2'b00:   return amt;
      2'b01:   return {1'b0, amt[4:0]};
      2'b10:   return {2'b0, amt[3:0]};
      default: return {3'b0, amt[2:0]};
    endcase
  endfunction

  logic [63:0]          c_data;
  logic [5:0]           c_amt;
  logic [2:0]           c_type;
  logic [1:0]           c_lane;
  logic [63:0]          c_res;
  logic                 c_sat;
  logic [64:0]          t;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    c_res = '0;
    c_sat = 1'b0;
    t     = '0;
    case (c_lane)
      2'b00: begin
        t     = lane_op(c_data, 64, c_amt, op_e'(c_type));
        c_res = t[63:0];
        c_sat = t[64];
      end
      2'b01: for (int i = 0; i < 2; i++) begin
        t = lane_op(64'(c_data[i*32 +: 32]), 32, c_amt, op_e'(c_type));
        c_res[i*32 +: 32] = t[31:0];
        c_sat = c_sat | t[64];
      end
      2'b10: for (int i = 0; i < 4; i++) begin
        t = lane_op(64'(c_data[i*16 +: 16]), 16, c_amt, op_e'(c_type));
        c_res[i*16 +: 16] = t[15:0];
        c_sat = c_sat | t[64];
      end
      default: for (int i = 0; i < 8; i++) begin
        t = lane_op(64'(c_data[i*8 +: 8]), 8, c_amt, op_e'(c_type));
        c_res[i*8 +: 8] = t[7:0];
        c_sat = c_sat | t[64];
      end
    endcase
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign in_ready = !out_valid || out_ready;
      assign c_data   = in_data;
      assign c_amt    = amt_eff(in_amt, in_lane);
      assign c_type   = in_type;
      assign c_lane   = in_lane;

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_tag   <= '0;
          out_sat   <= 1'b0;
        end else begin
          if (flush)         out_valid <= 1'b0;
          else if (in_ready) out_valid <= in_valid;
          if (in_ready && in_valid) begin
            out_data <= c_res;
            out_tag  <= in_tag;
            out_sat  <= c_sat;
          end
        end
      end
    end else begin : g_two
      logic                 s0_valid;
      logic [63:0]          s0_data;
      logic [5:0]           s0_amt;
      logic [2:0]           s0_type;
      logic [1:0]           s0_lane;
      logic [TAG_WIDTH-1:0] s0_tag;
      logic                 s1_load;

      assign s1_load  = !out_valid || out_ready;
      assign in_ready = !s0_valid || s1_load;
      assign c_data   = s0_data;
      assign c_amt    = s0_amt;
      assign c_type   = s0_type;
      assign c_lane   = s0_lane;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          // NOTE: payload registers are reset too; they are few and out_data must read 0 out of reset.
          s0_valid  <= 1'b0;
          s0_data   <= '0;
          s0_amt    <= '0;
          s0_type   <= '0;
          s0_lane   <= '0;
          s0_tag    <= '0;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_tag   <= '0;
          out_sat   <= 1'b0;
        end else begin
          if (flush)         s0_valid <= 1'b0;
          else if (in_ready) s0_valid <= in_valid;
          if (in_ready && in_valid) begin
            s0_data <= in_data;
            s0_amt  <= amt_eff(in_amt, in_lane);
            s0_type <= in_type;
            s0_lane <= in_lane;
            s0_tag  <= in_tag;
          end
          if (flush)        out_valid <= 1'b0;
          else if (s1_load) out_valid <= s0_valid;
          // Only a real op overwrites the output, so a held result never changes.
          if (s1_load && s0_valid) begin
            out_data <= c_res;
            out_tag  <= s0_tag;
            out_sat  <= c_sat;
          end
        end
      end
    end
  endgenerate

endmodule
